// File: rtl/barrier_scheduler.sv
// Frame-paced barrier spawner/judge: drives one-hot lane enables, judges hit/pass, keeps score/lives.
// Optional macro BARRIER_DIFFICULTY_RAMP_EN shortens the spawn gap as the score grows.
module barrier_scheduler #(
    parameter int unsigned GAP_FRAMES   = 8,
    parameter int unsigned DWELL_FRAMES = 36,
    parameter int unsigned LIVES        = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_v_sync,
    input  logic        i_start,
    input  logic [1:0]  i_player_lane,
    input  logic [2:0]  i_in_position,
    output logic [2:0]  o_active,
    output logic [15:0] o_score,
    output logic [1:0]  o_lives,
    output logic        o_hit_pulse,
    output logic        o_pass_pulse,
    output logic        o_game_over
);
    typedef enum logic [1:0] {IDLE, SPAWN_WAIT, ACTIVE, GAME_OVER} state_t;

    localparam logic [7:0] GAP_W   = 8'(GAP_FRAMES);
    localparam logic [7:0] DWELL_W = 8'(DWELL_FRAMES);
    localparam logic [1:0] LIVES_W = 2'(LIVES);

    typedef struct packed {
        logic hit;
        logic pass;
    } judge_t;

    state_t      state_q, state_d;
    logic        v_sync_q, tick;
    logic [15:0] lfsr_q, lfsr_d;
    logic        fb;
    logic [7:0]  cnt_q, cnt_d, cnt_inc, gap_eff;
    logic [1:0]  lane_q, lane_d, lane_pick, player;
    logic        judged_q, judged_d;
    logic [15:0] score_d;
    logic [1:0]  lives_d;
    judge_t      judge_d;

    assign tick      = i_v_sync & ~v_sync_q;
    assign fb        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lane_pick = (lfsr_q[1:0] == 2'd3) ? 2'd1 : lfsr_q[1:0];
    assign player    = (i_player_lane == 2'd3) ? 2'd1 : i_player_lane;
    assign cnt_inc   = cnt_q + 8'd1;

`ifdef BARRIER_DIFFICULTY_RAMP_EN
    // Gap shrinks by one frame per 4 points, floored at 2.
    logic [13:0] ramp_sub;
    assign ramp_sub = o_score[15:2];
    always_comb begin
        if ({2'b00, ramp_sub} + 16'd2 >= 16'(GAP_FRAMES))
            gap_eff = 8'd2;
        else
            gap_eff = GAP_W - ramp_sub[7:0];
    end
`else
    assign gap_eff = GAP_W;
`endif

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        judged_d = judged_q;
        score_d  = o_score;
        lives_d  = o_lives;
        judge_d  = '0;

        if (tick && state_q != GAME_OVER)
            lfsr_d = {lfsr_q[14:0], fb};

        case (state_q)
            IDLE, GAME_OVER: begin
                if (i_start) begin
                    state_d = SPAWN_WAIT;
                    score_d = 16'd0;
                    lives_d = LIVES_W;
                    lfsr_d  = LFSR_SEED;
                    cnt_d   = 8'd0;
                end
            end
            SPAWN_WAIT: begin
                if (tick) begin
                    if (cnt_inc == gap_eff) begin
                        lane_d   = lane_pick;
                        cnt_d    = 8'd0;
                        judged_d = 1'b0;
                        state_d  = ACTIVE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ACTIVE: begin
                if (tick) begin
                    if (cnt_inc == DWELL_W) begin
                        cnt_d   = 8'd0;
                        state_d = SPAWN_WAIT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                // Judgement overrides a same-cycle dwell expiry when it ends the game.
                if (!judged_q && i_in_position[lane_q]) begin
                    judged_d = 1'b1;
                    if (player == lane_q) begin
                        judge_d.hit = 1'b1;
                        lives_d     = o_lives - 2'd1;
                        if (o_lives == 2'd1)
                            state_d = GAME_OVER;
                    end else begin
                        judge_d.pass = 1'b1;
                        if (o_score != 16'hFFFF)
                            score_d = o_score + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            v_sync_q     <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            cnt_q        <= 8'd0;
            lane_q       <= 2'd0;
            judged_q     <= 1'b0;
            o_active     <= 3'b000;
            o_score      <= 16'd0;
            o_lives      <= LIVES_W;
            o_hit_pulse  <= 1'b0;
            o_pass_pulse <= 1'b0;
            o_game_over  <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_sync_q     <= i_v_sync;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            judged_q     <= judged_d;
            o_active     <= (state_d == ACTIVE) ? (3'b001 << lane_d) : 3'b000;
            o_score      <= score_d;
            o_lives      <= lives_d;
            o_hit_pulse  <= judge_d.hit;
            o_pass_pulse <= judge_d.pass;
            o_game_over  <= (state_d == GAME_OVER);
        end
    end
endmodule

// File: tb/tb_barrier_scheduler.sv
// Directed bench for barrier_scheduler: spawn timing, pass/hit judging, game over, restart, ramp, async reset.
module tb_barrier_scheduler;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          DWELL = 36;

    logic        clk, rst, v_sync, start;
    logic [1:0]  player;
    logic [2:0]  in_pos;
    logic [2:0]  o_active;
    logic [15:0] o_score;
    logic [1:0]  o_lives;
    logic        o_hit_pulse, o_pass_pulse, o_game_over;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] ml, last_l;
    logic [1:0]  lane, hit_lane, miss_lane;
    logic [2:0]  oh;
    int          act_seen;

    barrier_scheduler dut (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_start(start),
        .i_player_lane(player), .i_in_position(in_pos),
        .o_active(o_active), .o_score(o_score), .o_lives(o_lives),
        .o_hit_pulse(o_hit_pulse), .o_pass_pulse(o_pass_pulse), .o_game_over(o_game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [1:0] pick(input logic [15:0] l);
        return (l[1:0] == 2'd3) ? 2'd1 : l[1:0];
    endfunction

    function automatic int exp_gap(input int s);
`ifdef BARRIER_DIFFICULTY_RAMP_EN
        case (s)
            4:       return 7;
            8:       return 6;
            24:      return 2;
            default: return (8 - s / 4 < 2) ? 2 : 8 - s / 4;
        endcase
`else
        return 8;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) v_sync = 1'b1;
        last_l = ml;
        ml = lfsr_nx(ml);
        @(negedge clk) v_sync = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        ml = SEED;
        @(negedge clk) start = 1'b0;
    endtask

    // Ticks until a barrier appears (bounded), then checks gap length and lane.
    task automatic spawn(input int gap, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (o_active == 3'b000 && n < 300);
        lane      = pick(last_l);
        oh        = 3'b001 << lane;
        hit_lane  = (lane == 2'd1) ? 2'd3 : lane;
        miss_lane = (lane == 2'd1) ? 2'd0 : 2'd3;
        chk({tag, "_gap"}, 32'(n), 32'(gap));
        chk({tag, "_lane"}, 32'(o_active), 32'(oh));
    endtask

    task automatic dwell(input string tag);
        repeat (DWELL - 1) tick();
        chk({tag, "_held"}, 32'(o_active), 32'(oh));
        tick();
        chk({tag, "_off"}, 32'(o_active), 32'd0);
    endtask

    task automatic hit(input logic [1:0] lives_exp, input string tag);
        @(negedge clk) begin in_pos = oh; player = hit_lane; end
        @(negedge clk) in_pos = 3'b000;
        chk({tag, "_hpulse"}, 32'(o_hit_pulse), 32'd1);
        chk({tag, "_lives"}, 32'(o_lives), 32'(lives_exp));
        @(negedge clk);
        chk({tag, "_hpulse_end"}, 32'(o_hit_pulse), 32'd0);
    endtask

    initial begin
        rst = 1'b1; v_sync = 1'b0; start = 1'b0; player = 2'd0; in_pos = 3'b000;
        ml = SEED; last_l = SEED; lane = 2'd0; oh = 3'b001; hit_lane = 2'd0; miss_lane = 2'd3;
        repeat (3) @(negedge clk);
        chk("rst_active", 32'(o_active), 32'd0);
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_lives", 32'(o_lives), 32'd3);
        chk("rst_flags", 32'({o_hit_pulse, o_pass_pulse, o_game_over}), 32'd0);
        rst = 1'b0;

        // Barrier 1: spawn timing, off-lane ignore, pass, dwell length.
        do_start();
        spawn(8, "b1");
        @(negedge clk) begin in_pos = ~oh; player = lane; end
        repeat (3) @(negedge clk);
        in_pos = 3'b000;
        chk("offlane_score", 32'(o_score), 32'd0);
        chk("offlane_lives", 32'(o_lives), 32'd3);
        chk("offlane_hpulse", 32'(o_hit_pulse), 32'd0);
        @(negedge clk) begin in_pos = oh; player = miss_lane; end
        @(negedge clk);
        chk("pass_pulse", 32'(o_pass_pulse), 32'd1);
        chk("pass_score", 32'(o_score), 32'd1);
        @(negedge clk);
        chk("pass_pulse_end", 32'(o_pass_pulse), 32'd0);
        repeat (3) @(negedge clk);
        in_pos = 3'b000;
        chk("pass_once", 32'(o_score), 32'd1);
        chk("pass_lives", 32'(o_lives), 32'd3);
        dwell("b1");

        // Barrier 2: start during ACTIVE is ignored, then a hit.
        spawn(8, "b2");
        do_start();
        ml = last_l; ml = lfsr_nx(ml);
        chk("start_ign_active", 32'(o_active), 32'(oh));
        chk("start_ign_score", 32'(o_score), 32'd1);
        hit(2'd2, "b2");
        dwell("b2");

        spawn(8, "b3");
        hit(2'd1, "b3");
        dwell("b3");

        // Barrier 4: final hit lands on the dwell-expiry tick.
        spawn(8, "b4");
        repeat (DWELL - 1) tick();
        @(negedge clk) begin v_sync = 1'b1; in_pos = oh; player = hit_lane; end
        @(negedge clk) begin v_sync = 1'b0; in_pos = 3'b000; end
        chk("sim_lives", 32'(o_lives), 32'd0);
        chk("sim_hpulse", 32'(o_hit_pulse), 32'd1);
        chk("sim_gameover", 32'(o_game_over), 32'd1);
        chk("sim_active", 32'(o_active), 32'd0);

        act_seen = 0;
        repeat (100) begin
            tick();
            if (o_active != 3'b000) act_seen++;
        end
        chk("go_no_spawn", 32'(act_seen), 32'd0);
        chk("go_held", 32'(o_game_over), 32'd1);
        chk("go_score_frozen", 32'(o_score), 32'd1);
        chk("go_lives_frozen", 32'(o_lives), 32'd0);

        do_start();
        chk("restart_lives", 32'(o_lives), 32'd3);
        chk("restart_score", 32'(o_score), 32'd0);
        chk("restart_go", 32'(o_game_over), 32'd0);

        // Score ramp: one pass per barrier, gap measured before each spawn.
        for (int s = 0; s <= 24; s++) begin
            spawn(exp_gap(s), $sformatf("ramp%0d", s));
            if (s < 24) begin
                @(negedge clk) begin in_pos = oh; player = miss_lane; end
                @(negedge clk) in_pos = 3'b000;
                dwell($sformatf("ramp%0d", s));
            end
        end
        chk("ramp_score", 32'(o_score), 32'd24);

        // Async reset mid-ACTIVE, observed before the next rising edge.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_active", 32'(o_active), 32'd0);
        chk("arst_score", 32'(o_score), 32'd0);
        chk("arst_lives", 32'(o_lives), 32'd3);
        chk("arst_go", 32'(o_game_over), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
